// File: rtl/fft_pkg.sv
// Shared definitions for the power integration stage.
// Holds the lane/column geometry, the power and accumulator lane types,
// the accumulator state enum and the saturating lane adder.
package fft_pkg;

    localparam int IN_WIDTH  = 52;    // one power lane from the |X|^2 stage
    localparam int ACC_WIDTH = 60;    // integrated lane, saturating
    localparam int NUM_COLS  = 2048;  // column slots in the accumulator array
    localparam int IDX_WIDTH = 11;    // clog2(NUM_COLS)
    localparam int FRM_WIDTH = 8;     // frame-count configuration width
    localparam int LANES     = 4;     // lanes per column

    typedef logic [IN_WIDTH-1:0]  pwr_t;
    typedef logic [ACC_WIDTH-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_t;

    // Unsigned add of a power lane into an accumulator lane, clamped to all-ones.
    function automatic acc_t sat_add(input acc_t acc, input pwr_t pwr);
        logic [ACC_WIDTH:0] sum;
        sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, pwr};
        return sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/power_accumulator_acc_lane_update.sv
// acc_lane_update: combinational next value for one accumulator lane.
// Ports:
//   old_val     - current accumulator lane contents
//   in_val      - incoming power lane
//   first_write - column has not been written in this run; old_val is stale
//   new_val     - value to store at the next clock edge
module acc_lane_update
    import fft_pkg::*;
(
    input  acc_t old_val,
    input  pwr_t in_val,
    input  logic first_write,
    output acc_t new_val
);

    // A first write replaces whatever stale contents the register holds,
    // so the array never needs a bulk clear between runs.
    always_comb begin
        if (first_write) begin
            new_val = {{(ACC_WIDTH - IN_WIDTH){1'b0}}, in_val};
        end else begin
            new_val = sat_add(old_val, in_val);
        end
    end

endmodule

// File: rtl/power_accumulator.sv
// power_accumulator: integrates |X|^2 power per column and lane over a
// configured number of frames, then streams the integrated spectrum out.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   start, cfg_frames        - begin a run (IDLE only); frames per run (0 -> 1)
//   in_valid, in_last        - power beat strobe; last beat of a frame
//   in_col1/in_col2          - 4 power lanes for two columns
//   in_idx_col1/in_idx_col2  - column index of each input column
//   out_valid/out_ready      - dump handshake
//   out_data/out_index/out_last - integrated lanes, column, final beat flag
//   busy, done               - run in progress; pulse after last dump beat
//   err_drop, err_dup        - sticky: beat outside ACCUM; duplicate col2 index
//   dbg_state                - current FSM state
module power_accumulator
    import fft_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [FRM_WIDTH-1:0]         cfg_frames,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [LANES*IN_WIDTH-1:0]    in_col1,
    input  logic [LANES*IN_WIDTH-1:0]    in_col2,
    input  logic [IDX_WIDTH-1:0]         in_idx_col1,
    input  logic [IDX_WIDTH-1:0]         in_idx_col2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ACC_WIDTH-1:0]   out_data,
    output logic [IDX_WIDTH-1:0]         out_index,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err_drop,
    output logic                         err_dup,
    output state_t                       dbg_state
);

    state_t                 state, state_nxt;
    logic [FRM_WIDTH-1:0]   frames;
    logic [FRM_WIDTH-1:0]   frame_cnt;
    logic [FRM_WIDTH:0]     frame_cnt_inc;
    logic [IDX_WIDTH-1:0]   rd_ptr;
    logic [NUM_COLS-1:0]    written;
    acc_t                   acc [NUM_COLS][LANES];
    acc_t                   new1 [LANES];
    acc_t                   new2 [LANES];

    logic beat_accum;
    logic col2_en;
    logic dup_hit;
    logic wr1;
    logic wr2;
    logic frame_end;
    logic dump_fire;
    logic dump_end;

    // Column 2 carries real data only when column 1 is index 2 or above;
    // below that the power stage zeroes it and it is ignored.
    assign beat_accum    = in_valid && (state == ACCUM);
    assign col2_en       = (in_idx_col1 >= IDX_WIDTH'(2));
    assign dup_hit       = col2_en && (in_idx_col2 == in_idx_col1);
    assign wr1           = beat_accum;
    assign wr2           = beat_accum && col2_en && !dup_hit;
    assign frame_cnt_inc = {1'b0, frame_cnt} + {{FRM_WIDTH{1'b0}}, 1'b1};
    assign frame_end     = beat_accum && in_last && (frame_cnt_inc == {1'b0, frames});

    // Dump handshake: a beat transfers on a clock edge where out_valid and
    // out_ready are both high; out_valid never drops and out_data/out_index/
    // out_last never change until that transfer happens.
    assign dump_fire = (state == DUMP) && out_ready;
    assign dump_end  = dump_fire && (rd_ptr == IDX_WIDTH'(NUM_COLS - 1));

    // Both columns read the register array combinationally, so a beat hitting
    // the index written on the previous edge sees the updated value.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        acc_lane_update u_upd1 (
            .old_val     (acc[in_idx_col1][g]),
            .in_val      (in_col1[g*IN_WIDTH +: IN_WIDTH]),
            .first_write (!written[in_idx_col1]),
            .new_val     (new1[g])
        );
        acc_lane_update u_upd2 (
            .old_val     (acc[in_idx_col2][g]),
            .in_val      (in_col2[g*IN_WIDTH +: IN_WIDTH]),
            .first_write (!written[in_idx_col2]),
            .new_val     (new2[g])
        );
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)     state_nxt = ACCUM;
            ACCUM:   if (frame_end) state_nxt = DUMP;
            DUMP:    if (dump_end)  state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            frames    <= '0;
            frame_cnt <= '0;
            rd_ptr    <= '0;
            written   <= '0;
            err_drop  <= 1'b0;
            err_dup   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= dump_end;
            if ((state == IDLE) && start) begin
                frames    <= (cfg_frames == '0) ? FRM_WIDTH'(1) : cfg_frames;
                frame_cnt <= '0;
                written   <= '0;
                err_drop  <= 1'b0;
                err_dup   <= 1'b0;
            end else begin
                if (in_valid && (state != ACCUM)) err_drop <= 1'b1;
                if (beat_accum && dup_hit)        err_dup  <= 1'b1;
                if (wr1) written[in_idx_col1] <= 1'b1;
                if (wr2) written[in_idx_col2] <= 1'b1;
                if (beat_accum && in_last) frame_cnt <= frame_cnt_inc[FRM_WIDTH-1:0];
            end
            if (frame_end) begin
                rd_ptr <= '0;
            end else if (dump_fire) begin
                rd_ptr <= rd_ptr + IDX_WIDTH'(1);
            end
        end
    end

    // Array contents carry no reset; the written bitmap masks stale entries.
    always_ff @(posedge clk) begin
        if (wr1) begin
            for (int l = 0; l < LANES; l++) acc[in_idx_col1][l] <= new1[l];
        end
        if (wr2) begin
            for (int l = 0; l < LANES; l++) acc[in_idx_col2][l] <= new2[l];
        end
    end

    assign out_valid = (state == DUMP);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_index = rd_ptr;
            out_last  = (rd_ptr == IDX_WIDTH'(NUM_COLS - 1));
            if (written[rd_ptr]) begin
                for (int l = 0; l < LANES; l++) begin
                    out_data[l*ACC_WIDTH +: ACC_WIDTH] = acc[rd_ptr][l];
                end
            end
        end
    end

endmodule

// File: tb/tb_power_accumulator.sv
module tb_power_accumulator;
    import fft_pkg::*;

    localparam int CW = LANES * IN_WIDTH;
    localparam int DW = LANES * ACC_WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [7:0]      cfg_frames;
    logic            in_valid;
    logic            in_last;
    logic [CW-1:0]   in_col1;
    logic [CW-1:0]   in_col2;
    logic [10:0]     in_idx_col1;
    logic [10:0]     in_idx_col2;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [10:0]     out_index;
    logic            out_last;
    logic            busy;
    logic            done;
    logic            err_drop;
    logic            err_dup;
    state_t          dbg_state;

    power_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .cfg_frames(cfg_frames),
        .in_valid(in_valid), .in_last(in_last),
        .in_col1(in_col1), .in_col2(in_col2),
        .in_idx_col1(in_idx_col1), .in_idx_col2(in_idx_col2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
        .err_drop(err_drop), .err_dup(err_dup), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: unbounded per-lane sums, clamped only when read out.
    localparam logic [79:0] MAX_ACC = (80'd1 << ACC_WIDTH) - 80'd1;
    localparam logic [79:0] MAX_IN  = (80'd1 << IN_WIDTH) - 80'd1;
    logic [79:0] m_sum [NUM_COLS][LANES];
    bit          m_wr  [NUM_COLS];
    bit          m_accum;
    int          m_frames;
    int          m_fcnt;
    bit          m_drop;
    bit          m_dup;

    // Capture of one dump.
    logic [DW-1:0] cap_data [NUM_COLS];
    int            cap_cnt  [NUM_COLS];
    int last_cnt, last_bad, order_bad, hold_bad, done_cnt, post_valid, idle_data_bad;
    bit timeout;

    function automatic logic [DW-1:0] exp_col(input int c);
        logic [DW-1:0] r;
        r = '0;
        if (m_wr[c]) begin
            for (int l = 0; l < LANES; l++) begin
                r[l*ACC_WIDTH +: ACC_WIDTH] = (m_sum[c][l] > MAX_ACC) ? MAX_ACC[59:0] : m_sum[c][l][59:0];
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] fill_in(input logic [51:0] v);
        return {4{v}};
    endfunction

    function automatic logic [DW-1:0] fill_acc(input logic [59:0] v);
        return {4{v}};
    endfunction

    function automatic logic [51:0] rand_lane();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[51:0];
    endfunction

    function automatic logic [CW-1:0] rand_col();
        return {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
    endfunction

    task automatic m_add(input int idx, input logic [CW-1:0] v);
        if (!m_wr[idx]) begin
            m_wr[idx] = 1'b1;
            for (int l = 0; l < LANES; l++) m_sum[idx][l] = '0;
        end
        for (int l = 0; l < LANES; l++) m_sum[idx][l] += {28'd0, v[l*IN_WIDTH +: IN_WIDTH]};
    endtask

    // Driver: one power beat; the scoreboard model is updated from the same stimulus.
    task automatic drive_beat(input bit last, input logic [CW-1:0] c1, input logic [10:0] i1,
                              input logic [CW-1:0] c2, input logic [10:0] i2);
        if (!m_accum) begin
            m_drop = 1'b1;
        end else begin
            m_add(int'(i1), c1);
            if (i1 >= 11'd2) begin
                if (i2 == i1) m_dup = 1'b1;
                else m_add(int'(i2), c2);
            end
            if (last) begin
                m_fcnt++;
                if (m_fcnt == m_frames) m_accum = 1'b0;
            end
        end
        in_valid = 1'b1; in_last = last;
        in_col1 = c1; in_idx_col1 = i1; in_col2 = c2; in_idx_col2 = i2;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] f);
        start = 1'b1; cfg_frames = f;
        @(posedge clk); #1;
        start = 1'b0;
        m_accum = 1'b1; m_frames = (f == 0) ? 1 : int'(f); m_fcnt = 0;
        m_drop = 1'b0; m_dup = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) m_wr[c] = 1'b0;
    endtask

    // Monitor: drives out_ready (0 always, 1 pattern 1,0,0,1, 2 random) and
    // records every accepted beat until NUM_COLS beats or the cycle budget.
    task automatic run_dump(input int mode);
        int accepted = 0;
        int cyc = 0;
        int exp_ptr = 0;
        bit prev_stall = 1'b0;
        logic [10:0] prev_idx = '0;
        for (int c = 0; c < NUM_COLS; c++) cap_cnt[c] = 0;
        last_cnt = 0; last_bad = 0; order_bad = 0; hold_bad = 0;
        done_cnt = 0; post_valid = 0; idle_data_bad = 0;
        while (accepted < NUM_COLS && cyc < 20000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (done) done_cnt++;
            if (out_valid) begin
                if (prev_stall && out_index !== prev_idx) hold_bad++;
                if (out_index !== 11'(exp_ptr)) order_bad++;
                if (out_last !== (out_index == 11'd2047)) last_bad++;
                if (out_ready) begin
                    cap_data[out_index] = out_data;
                    cap_cnt[out_index]++;
                    if (out_last) last_cnt++;
                    accepted++; exp_ptr++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_idx = out_index;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        timeout = (accepted < NUM_COLS);
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (out_valid) post_valid++;
            if (out_data !== '0 || out_index !== '0 || out_last !== 1'b0) idle_data_bad++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; cfg_frames = 0; in_valid = 0; in_last = 0;
        in_col1 = '0; in_col2 = '0; in_idx_col1 = '0; in_idx_col2 = '0; out_ready = 0;
        m_accum = 0; m_drop = 0; m_dup = 0;
        for (int c = 0; c < NUM_COLS; c++) m_wr[c] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data: got %h need 0", out_data); end
        n_checks++; if (out_index !== '0 || out_last !== 1'b0) begin n_errors++; $display("FAIL reset_index_last: got %0d/%b need 0/0", out_index, out_last); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL reset_busy_done: got %b/%b need 0/0", busy, done); end
        n_checks++; if (err_drop !== 1'b0 || err_dup !== 1'b0) begin n_errors++; $display("FAIL reset_errs: got %b/%b need 0/0", err_drop, err_dup); end
        n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d need %0d", dbg_state, IDLE); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int bad = 0;
        do_start(8'd2);
        n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin n_errors++; $display("FAIL basic_accum_outputs: busy %b valid %b data %h need 1/0/0", busy, out_valid, out_data); end
        drive_beat(1'b1, fill_in(52'd100), 11'd5, fill_in(52'd7), 11'd6);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_dump: got valid %b after frame 1 need 0", out_valid); end
        drive_beat(1'b1, fill_in(52'd100), 11'd5, fill_in(52'd7), 11'd6);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_index !== 11'd0) begin n_errors++; $display("FAIL basic_dump_latency: got valid %b idx %0d need 1/0", out_valid, out_index); end
        @(posedge clk); #1;
        run_dump(0);
        for (int c = 0; c < NUM_COLS; c++) if (cap_cnt[c] != 1 || cap_data[c] !== exp_col(c)) bad++;
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL basic_columns: %0d wrong columns need 0", bad); end
        n_checks++; if (cap_data[5] !== fill_acc(60'd200)) begin n_errors++; $display("FAIL basic_col5: got %h need %h", cap_data[5], fill_acc(60'd200)); end
        n_checks++; if (cap_data[6] !== fill_acc(60'd14)) begin n_errors++; $display("FAIL basic_col6: got %h need %h", cap_data[6], fill_acc(60'd14)); end
        n_checks++; if (cap_data[7] !== '0 || cap_data[0] !== '0) begin n_errors++; $display("FAIL basic_unwritten: got %h/%h need 0", cap_data[7], cap_data[0]); end
        n_checks++; if (last_cnt != 1 || last_bad != 0) begin n_errors++; $display("FAIL basic_out_last: got count %0d bad %0d need 1/0", last_cnt, last_bad); end
        n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL basic_done: got %0d pulses need 1", done_cnt); end
        n_checks++; if (timeout || order_bad != 0 || post_valid != 0 || idle_data_bad != 0) begin n_errors++; $display("FAIL basic_stream: timeout %b order %0d post %0d idle %0d need 0", timeout, order_bad, post_valid, idle_data_bad); end
        n_checks++; if (busy !== 1'b0 || err_dup !== 1'b0) begin n_errors++; $display("FAIL basic_end_state: busy %b dup %b need 0/0", busy, err_dup); end
    endtask

    task automatic test_col2_gate();
        int bad = 0;
        logic [CW-1:0] c1v;
        c1v = rand_col();
        do_start(8'd1);
        drive_beat(1'b1, c1v, 11'd1, fill_in(52'd999), 11'd3);
        run_dump(2);
        for (int c = 0; c < NUM_COLS; c++) if (cap_cnt[c] != 1 || cap_data[c] !== exp_col(c)) bad++;
        n_checks++; if (bad != 0 || timeout) begin n_errors++; $display("FAIL gate_columns: %0d wrong columns timeout %b need 0", bad, timeout); end
        n_checks++; if (cap_data[3] !== '0) begin n_errors++; $display("FAIL gate_col3: got %h need 0", cap_data[3]); end
        n_checks++; if (cap_data[1] !== {8'd0, c1v[207:156], 8'd0, c1v[155:104], 8'd0, c1v[103:52], 8'd0, c1v[51:0]}) begin n_errors++; $display("FAIL gate_col1: got %h", cap_data[1]); end
        n_checks++; if (err_dup !== 1'b0 || done_cnt != 1) begin n_errors++; $display("FAIL gate_flags: dup %b done %0d need 0/1", err_dup, done_cnt); end
    endtask

    task automatic test_random();
        int bad = 0;
        int nfr;
        int nb;
        logic [10:0] i1, i2;
        nfr = $urandom_range(2, 3);
        do_start(8'(nfr));
        drive_beat(1'b0, rand_col(), 11'd7, rand_col(), 11'd7);
        n_checks++; if (err_dup !== 1'b1) begin n_errors++; $display("FAIL dup_flag: got %b need 1", err_dup); end
        for (int f = 0; f < nfr; f++) begin
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                i1 = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 8)) : 11'($urandom_range(0, 2047));
                i2 = ($urandom_range(0, 3) == 0) ? i1 : 11'($urandom_range(0, 8));
                drive_beat(b == nb - 1, rand_col(), i1, rand_col(), i2);
            end
        end
        run_dump(2);
        for (int c = 0; c < NUM_COLS; c++) if (cap_cnt[c] != 1 || cap_data[c] !== exp_col(c)) bad++;
        n_checks++; if (bad != 0 || timeout) begin n_errors++; $display("FAIL random_columns: %0d wrong columns timeout %b need 0", bad, timeout); end
        n_checks++; if (err_dup !== m_dup || err_drop !== m_drop) begin n_errors++; $display("FAIL random_flags: dup %b drop %b need %b/%b", err_dup, err_drop, m_dup, m_drop); end
        n_checks++; if (hold_bad != 0 || order_bad != 0 || done_cnt != 1) begin n_errors++; $display("FAIL random_stream: hold %0d order %0d done %0d need 0/0/1", hold_bad, order_bad, done_cnt); end
    endtask

    task automatic test_saturation();
        int bad = 0;
        logic [79:0] rem;
        logic [51:0] v;
        logic [CW-1:0] c1;
        rem = (80'd1 << 60) - 80'd10;
        do_start(8'd1);
        while (rem != 0) begin
            v = (rem > MAX_IN) ? MAX_IN[51:0] : rem[51:0];
            rem -= {28'd0, v};
            c1 = {52'($urandom_range(0, 1000)), v, 52'($urandom_range(0, 1000)), 52'($urandom_range(0, 1000))};
            drive_beat(1'b0, c1, 11'd100, fill_in(52'($urandom_range(0, 50))), 11'd101);
        end
        drive_beat(1'b1, {52'd3, 52'd25, 52'd2, 52'd1}, 11'd100, fill_in(52'd0), 11'd101);
        run_dump(0);
        for (int c = 0; c < NUM_COLS; c++) if (cap_cnt[c] != 1 || cap_data[c] !== exp_col(c)) bad++;
        n_checks++; if (bad != 0 || timeout) begin n_errors++; $display("FAIL sat_columns: %0d wrong columns timeout %b need 0", bad, timeout); end
        n_checks++; if (cap_data[100][2*ACC_WIDTH +: ACC_WIDTH] !== 60'hFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL sat_lane2: got %h need fffffffffffffff", cap_data[100][2*ACC_WIDTH +: ACC_WIDTH]); end
        n_checks++; if (cap_data[100][ACC_WIDTH-1:0] > 60'd300000) begin n_errors++; $display("FAIL sat_lane0_leak: got %h need small", cap_data[100][ACC_WIDTH-1:0]); end
    endtask

    task automatic test_stall();
        int bad = 0;
        do_start(8'd1);
        drive_beat(1'b1, fill_in(52'd11), 11'd2047, fill_in(52'd12), 11'd2046);
        run_dump(1);
        for (int c = 0; c < NUM_COLS; c++) if (cap_cnt[c] != 1 || cap_data[c] !== exp_col(c)) bad++;
        n_checks++; if (bad != 0 || timeout) begin n_errors++; $display("FAIL stall_columns: %0d wrong columns timeout %b need 0", bad, timeout); end
        n_checks++; if (hold_bad != 0 || order_bad != 0) begin n_errors++; $display("FAIL stall_hold: hold %0d order %0d need 0/0", hold_bad, order_bad); end
        n_checks++; if (cap_data[2047] !== fill_acc(60'd11) || cap_data[2046] !== fill_acc(60'd12)) begin n_errors++; $display("FAIL stall_top_cols: got %h/%h", cap_data[2047], cap_data[2046]); end
        n_checks++; if (done_cnt != 1 || last_cnt != 1 || last_bad != 0) begin n_errors++; $display("FAIL stall_done_last: done %0d last %0d bad %0d need 1/1/0", done_cnt, last_cnt, last_bad); end
    endtask

    task automatic test_err_drop();
        int bad = 0;
        drive_beat(1'b1, fill_in(52'd5), 11'd20, fill_in(52'd5), 11'd21);
        n_checks++; if (err_drop !== 1'b1) begin n_errors++; $display("FAIL drop_idle: got %b need 1", err_drop); end
        do_start(8'd1);
        n_checks++; if (err_drop !== 1'b0 || err_dup !== 1'b0) begin n_errors++; $display("FAIL drop_cleared: got %b/%b need 0/0", err_drop, err_dup); end
        drive_beat(1'b1, fill_in(52'd77), 11'd30, fill_in(52'd3), 11'd31);
        drive_beat(1'b0, fill_in(52'd1000), 11'd30, fill_in(52'd1000), 11'd31);
        n_checks++; if (err_drop !== 1'b1 || out_valid !== 1'b1) begin n_errors++; $display("FAIL drop_dump: drop %b valid %b need 1/1", err_drop, out_valid); end
        run_dump(0);
        for (int c = 0; c < NUM_COLS; c++) if (cap_cnt[c] != 1 || cap_data[c] !== exp_col(c)) bad++;
        n_checks++; if (bad != 0 || timeout) begin n_errors++; $display("FAIL drop_columns: %0d wrong columns timeout %b need 0", bad, timeout); end
        n_checks++; if (cap_data[30] !== fill_acc(60'd77) || cap_data[31] !== fill_acc(60'd3) || cap_data[20] !== '0) begin n_errors++; $display("FAIL drop_unchanged: got %h/%h/%h", cap_data[30], cap_data[31], cap_data[20]); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        do_start(8'd3);
        drive_beat(1'b0, fill_in(52'd9), 11'd40, fill_in(52'd8), 11'd41);
        drive_beat(1'b0, fill_in(52'd9), 11'd41, fill_in(52'd8), 11'd40);
        drive_beat(1'b0, fill_in(52'd9), 11'd10, fill_in(52'd8), 11'd40);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || dbg_state !== IDLE || out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_async: busy %b state %0d valid %b need 0/IDLE/0", busy, dbg_state, out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_accum = 1'b0; m_drop = 1'b0; m_dup = 1'b0;
        n_checks++; if (done !== 1'b0 || err_drop !== 1'b0 || err_dup !== 1'b0) begin n_errors++; $display("FAIL midrst_flags: done %b drop %b dup %b need 0", done, err_drop, err_dup); end
        do_start(8'd0);
        drive_beat(1'b1, fill_in(52'd42), 11'd10, fill_in(52'd6), 11'd12);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_frames0: valid %b need 1", out_valid); end
        @(posedge clk); #1;
        run_dump(0);
        for (int c = 0; c < NUM_COLS; c++) if (cap_cnt[c] != 1 || cap_data[c] !== exp_col(c)) bad++;
        n_checks++; if (bad != 0 || timeout) begin n_errors++; $display("FAIL midrst_columns: %0d wrong columns timeout %b need 0", bad, timeout); end
        n_checks++; if (cap_data[10] !== fill_acc(60'd42) || cap_data[40] !== '0 || cap_data[41] !== '0) begin n_errors++; $display("FAIL midrst_cols: got %h/%h/%h", cap_data[10], cap_data[40], cap_data[41]); end
        n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL midrst_done: got %0d need 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_col2_gate();
        test_random();
        test_saturation();
        test_stall();
        test_err_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
